// File: rtl/mage_stream_buffer.sv
// Elastic first-word-fall-through buffer for one DMA stream channel.
// It decouples DMA burst timing from PEA stalls, reports its fill level, and
// records any push attempted while the buffer is full.
module mage_stream_buffer #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned AF_THRESH = DEPTH - 1
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     clear_i,
   input  logic                     push_valid_i,
   input  logic [WIDTH-1:0]         push_data_i,
   output logic                     push_ready_o,
   output logic                     pop_valid_o,
   output logic [WIDTH-1:0]         pop_data_o,
   input  logic                     pop_ready_i,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     almost_full_o,
   output logic                     empty_o,
   output logic                     overflow_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   localparam logic [PW-1:0] AfThresh = PW'(AF_THRESH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic             overflow_q, overflow_d;
   logic             full, empty;
   logic             push_fire, pop_fire;

   // Status flags, derived only from the registered pointers.
   always_comb begin
      full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      empty   = (wr_ptr_q == rd_ptr_q);
      level_o = wr_ptr_q - rd_ptr_q;
   end

   // Handshakes and outputs; head word is read straight from storage.
   always_comb begin
      push_ready_o  = !full;
      pop_valid_o   = !empty;
      pop_data_o    = mem_q[rd_ptr_q[AW-1:0]];
      empty_o       = empty;
      almost_full_o = (level_o >= AfThresh);
      overflow_o    = overflow_q;
      push_fire     = push_valid_i && !full;
      pop_fire      = pop_ready_i && !empty;
   end

   // Next-state pointers and overflow flag; clear wins over any handshake.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      if (clear_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         overflow_d = 1'b0;
      end else begin
         if (push_fire) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_fire)  rd_ptr_d = rd_ptr_q + PW'(1);
         // A push while full is dropped, even if a pop frees a slot this cycle.
         if (push_valid_i && full) overflow_d = 1'b1;
      end
   end

   // Pointer and flag registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage write; the slot under rd_ptr is never written while it holds valid data.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_fire && !clear_i) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

endmodule

// File: tb/tb_mage_stream_buffer.sv
// Directed bench for mage_stream_buffer (WIDTH=32, DEPTH=4, AF_THRESH=3).
module tb_mage_stream_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        push_valid;
   logic [31:0] push_data;
   logic        push_ready;
   logic        pop_valid;
   logic [31:0] pop_data;
   logic        pop_ready;
   logic [2:0]  level;
   logic        almost_full;
   logic        empty;
   logic        overflow;

   int n_checks = 0;
   int n_fail   = 0;

   mage_stream_buffer #(
      .WIDTH     (32),
      .DEPTH     (4),
      .AF_THRESH (3)
   ) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .clear_i       (clear),
      .push_valid_i  (push_valid),
      .push_data_i   (push_data),
      .push_ready_o  (push_ready),
      .pop_valid_o   (pop_valid),
      .pop_data_o    (pop_data),
      .pop_ready_i   (pop_ready),
      .level_o       (level),
      .almost_full_o (almost_full),
      .empty_o       (empty),
      .overflow_o    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push_valid = 1'b0;
      pop_ready  = 1'b0;
      clear      = 1'b0;
   endtask

   task automatic push_one(input logic [31:0] d);
      push_valid = 1'b1;
      push_data  = d;
      pop_ready  = 1'b0;
      tick();
      push_valid = 1'b0;
   endtask

   logic [31:0] exp_words [4];
   logic [31:0] q [$];
   int          tx, rx, cnt;
   logic        pf, pp;

   initial begin
      exp_words[0] = 32'h11; exp_words[1] = 32'h22;
      exp_words[2] = 32'h33; exp_words[3] = 32'h44;
      idle();
      push_data = '0;
      rst_n     = 1'b0;
      #3;
      check_eq("rst_level",      32'(level), 0);
      check_eq("rst_push_ready", 32'(push_ready), 1);
      check_eq("rst_pop_valid",  32'(pop_valid), 0);
      check_eq("rst_pop_data",   pop_data, 0);
      check_eq("rst_empty",      32'(empty), 1);
      check_eq("rst_af",         32'(almost_full), 0);
      check_eq("rst_overflow",   32'(overflow), 0);
      #4 rst_n = 1'b1;
      tick();

      // Fill with no pops
      for (int i = 0; i < 4; i++) begin
         push_one(exp_words[i]);
         check_eq("fill_level", 32'(level), i + 1);
         check_eq("fill_af", 32'(almost_full), (i + 1 >= 3) ? 1 : 0);
         check_eq("fill_head", pop_data, 32'h11);
      end
      check_eq("full_push_ready", 32'(push_ready), 0);

      // Push while full: dropped, overflow sets
      push_one(32'h55);
      check_eq("ovf_flag",  32'(overflow), 1);
      check_eq("ovf_level", 32'(level), 4);

      // Drain
      pop_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq("drain_valid", 32'(pop_valid), 1);
         check_eq("drain_data", pop_data, exp_words[i]);
         tick();
      end
      check_eq("drain_empty", 32'(empty), 1);
      check_eq("drain_level", 32'(level), 0);
      check_eq("ovf_sticky", 32'(overflow), 1);
      // Pop on empty is ignored
      tick();
      check_eq("empty_pop_level", 32'(level), 0);
      idle();

      // Simultaneous push+pop at level 2
      push_one(32'h61);
      push_one(32'h62);
      for (int i = 0; i < 3; i++) begin
         push_valid = 1'b1;
         push_data  = 32'h63 + 32'(i);
         pop_ready  = 1'b1;
         check_eq("sim_data", pop_data, 32'h61 + 32'(i));
         tick();
         check_eq("sim_level", 32'(level), 2);
      end
      push_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check_eq("sim_tail", pop_data, 32'h64 + 32'(i));
         tick();
      end
      check_eq("sim_empty", 32'(empty), 1);
      idle();

      // Stall stability
      push_one(32'hA5);
      tick();
      tick();
      check_eq("stall_hold", pop_data, 32'hA5);
      pop_ready = 1'b1;
      tick();
      idle();

      // Wrap: 10 words with random pop stalls, scoreboarded
      q.delete();
      tx = 0; rx = 0; cnt = 0;
      for (int cyc = 0; cyc < 300 && rx < 10; cyc++) begin
         push_valid = (tx < 10);
         push_data  = 32'(tx + 1);
         pop_ready  = ($urandom_range(0, 2) != 0);
         pf = push_valid && (cnt < 4);
         pp = pop_ready && (cnt > 0);
         check_eq("wrap_ready", 32'(push_ready), (cnt < 4) ? 1 : 0);
         if (pp) begin
            check_eq("wrap_data", pop_data, q.pop_front());
            rx++;
         end
         if (pf) begin
            q.push_back(32'(tx + 1));
            tx++;
         end
         cnt = cnt + (pf ? 1 : 0) - (pp ? 1 : 0);
         tick();
         check_eq("wrap_level", 32'(level), cnt);
      end
      check_eq("wrap_count", rx, 10);
      check_eq("wrap_ovf_kept", 32'(overflow), 1);
      idle();

      // Clear at level 3 with push+pop firing
      push_one(32'h71);
      push_one(32'h72);
      push_one(32'h73);
      check_eq("clr_pre_level", 32'(level), 3);
      push_valid = 1'b1; push_data = 32'h74; pop_ready = 1'b1; clear = 1'b1;
      tick();
      idle();
      check_eq("clr_level",      32'(level), 0);
      check_eq("clr_pop_valid",  32'(pop_valid), 0);
      check_eq("clr_overflow",   32'(overflow), 0);
      check_eq("clr_push_ready", 32'(push_ready), 1);
      push_one(32'hBEEF);
      check_eq("clr_next_valid", 32'(pop_valid), 1);
      check_eq("clr_next_data",  pop_data, 32'hBEEF);
      check_eq("clr_next_level", 32'(level), 1);

      // Asynchronous reset mid-operation at level 2
      push_one(32'h81);
      check_eq("rst2_pre_level", 32'(level), 2);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst2_level",      32'(level), 0);
      check_eq("rst2_pop_valid",  32'(pop_valid), 0);
      check_eq("rst2_pop_data",   pop_data, 0);
      check_eq("rst2_push_ready", 32'(push_ready), 1);
      check_eq("rst2_empty",      32'(empty), 1);
      #3 rst_n = 1'b1;
      tick();
      push_one(32'h99);
      check_eq("post_rst_data",  pop_data, 32'h99);
      check_eq("post_rst_level", 32'(level), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
